ysyx_22040386_pipe_reg: RTL and testbench

Parametrised pipeline stage register that replaces the hand-written per-signal inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries a control bundle (forced to a bubble value on flush or empty) and a data bundle (held or cleared). A valid/ready handshake replaces the separate stall and flush flag wiring. An optional skid entry breaks the combinational ready path, and a bubble counter supports performance and difftest debugging.

---
 rtl/ysyx_22040386_pipe_reg.sv | 145 ++++++++++++++
 tb/tb_ysyx_22040386_pipe_reg.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040386_pipe_reg.sv
// Generic inter-stage pipeline register with a valid/ready handshake, NOP bubble
// insertion on flush or empty, an optional skid entry and a bubble counter.
module ysyx_22040386_pipe_reg #(
  parameter int unsigned        CTRL_W         = 16,
  parameter int unsigned        DATA_W         = 224,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE    = 16'h0040,
  parameter bit                 DATA_FLUSH_CLR = 1'b1,
  parameter bit                 SKID           = 1'b1,
  parameter int unsigned        CNT_W          = 16
) (
  input  logic              i_PIPE_REG_clk,
  input  logic              i_PIPE_REG_rst_n,
  input  logic              i_PIPE_REG_flush,
  input  logic              i_PIPE_REG_in_valid,
  output logic              o_PIPE_REG_in_ready,
  input  logic [CTRL_W-1:0] i_PIPE_REG_ctrl,
  input  logic [DATA_W-1:0] i_PIPE_REG_data,
  output logic              o_PIPE_REG_out_valid,
  input  logic              i_PIPE_REG_out_ready,
  output logic [CTRL_W-1:0] o_PIPE_REG_ctrl,
  output logic [DATA_W-1:0] o_PIPE_REG_data,
  output logic [CNT_W-1:0]  o_PIPE_REG_bubble_cnt
);

  logic accept;
  logic [CNT_W-1:0] bubble_cnt_q;

  assign accept = i_PIPE_REG_in_valid & o_PIPE_REG_in_ready & ~i_PIPE_REG_flush;

  generate
    if (SKID == 1'b0) begin : g_single
      logic              valid_q;
      logic [CTRL_W-1:0] ctrl_q;
      logic [DATA_W-1:0] data_q;

      // NOTE: reset is sampled on the clock edge (synchronous), and all state uses <= so every register updates from pre-edge values.
      always_ff @(posedge i_PIPE_REG_clk) begin
        if (!i_PIPE_REG_rst_n) begin
          valid_q <= 1'b0;
          ctrl_q  <= CTRL_BUBBLE;
          data_q  <= '0;
        end else if (i_PIPE_REG_flush) begin
          valid_q <= 1'b0;
          ctrl_q  <= CTRL_BUBBLE;
          if (DATA_FLUSH_CLR) data_q <= '0;
        end else if (o_PIPE_REG_in_ready) begin
          valid_q <= accept;
          ctrl_q  <= accept ? i_PIPE_REG_ctrl : CTRL_BUBBLE;
          data_q  <= i_PIPE_REG_data;
        end
      end

      assign o_PIPE_REG_in_ready  = ~valid_q | i_PIPE_REG_out_ready;
      assign o_PIPE_REG_out_valid = valid_q;
      assign o_PIPE_REG_ctrl      = ctrl_q;
      assign o_PIPE_REG_data      = data_q;
    end else begin : g_skid
      typedef enum logic [1:0] {ST_EMPTY, ST_MAIN, ST_FULL} state_t;

      state_t            state_q;
      logic              ready_q;
      logic              issue;
      logic [CTRL_W-1:0] ctrl_q, skid_ctrl_q;
      logic [DATA_W-1:0] data_q, skid_data_q;

      assign issue = (state_q != ST_EMPTY) & i_PIPE_REG_out_ready;

      // ready_q is the registered image of (next state != FULL), so out_ready never reaches in_ready combinationally.
      always_ff @(posedge i_PIPE_REG_clk) begin
        if (!i_PIPE_REG_rst_n) begin
          state_q     <= ST_EMPTY;
          ready_q     <= 1'b1;
          ctrl_q      <= CTRL_BUBBLE;
          data_q      <= '0;
          // NOTE: the skid entry is a plain register pair, not a RAM, so resetting it is cheap and keeps its content defined.
          skid_ctrl_q <= CTRL_BUBBLE;
          skid_data_q <= '0;
        end else if (i_PIPE_REG_flush) begin
          state_q     <= ST_EMPTY;
          ready_q     <= 1'b1;
          ctrl_q      <= CTRL_BUBBLE;
          skid_ctrl_q <= CTRL_BUBBLE;
          if (DATA_FLUSH_CLR) begin
            data_q      <= '0;
            skid_data_q <= '0;
          end
        end else begin
          unique case (state_q)
            ST_EMPTY: begin
              if (accept) begin
                state_q <= ST_MAIN;
                ctrl_q  <= i_PIPE_REG_ctrl;
                data_q  <= i_PIPE_REG_data;
              end
            end
            ST_MAIN: begin
              if (accept && issue) begin
                ctrl_q <= i_PIPE_REG_ctrl;
                data_q <= i_PIPE_REG_data;
              end else if (accept) begin
                state_q     <= ST_FULL;
                ready_q     <= 1'b0;
                skid_ctrl_q <= i_PIPE_REG_ctrl;
                skid_data_q <= i_PIPE_REG_data;
              end else if (issue) begin
                state_q <= ST_EMPTY;
                ctrl_q  <= CTRL_BUBBLE;
              end
            end
            ST_FULL: begin
              if (issue) begin
                state_q     <= ST_MAIN;
                ready_q     <= 1'b1;
                ctrl_q      <= skid_ctrl_q;
                data_q      <= skid_data_q;
                skid_ctrl_q <= CTRL_BUBBLE;
              end
            end
            default: begin
              state_q <= ST_EMPTY;
              ready_q <= 1'b1;
              ctrl_q  <= CTRL_BUBBLE;
            end
          endcase
        end
      end

      assign o_PIPE_REG_in_ready  = ready_q;
      assign o_PIPE_REG_out_valid = (state_q != ST_EMPTY);
      assign o_PIPE_REG_ctrl      = ctrl_q;
      assign o_PIPE_REG_data      = data_q;
    end
  endgenerate

  always_ff @(posedge i_PIPE_REG_clk) begin
    if (!i_PIPE_REG_rst_n) begin
      bubble_cnt_q <= '0;
    end else if (!o_PIPE_REG_out_valid) begin
      bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
    end
  end

  assign o_PIPE_REG_bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_ysyx_22040386_pipe_reg.sv
// Directed bench: one vector table drives a SKID=0, a SKID=1 and a CNT_W=4 instance
// in lockstep, followed by hand-written ready-path and counter-wrap sequences.
module tb_ysyx_22040386_pipe_reg;

  localparam logic [15:0] BUB = 16'h0040;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [15:0] ctrl;
  logic [63:0] data;

  logic        rdy0, vld0, rdy1, vld1, rdy4, vld4;
  logic [15:0] oc0, oc1, oc4, cnt0, cnt1;
  logic [63:0] od0, od1, od4;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22040386_pipe_reg #(.CTRL_W(16), .DATA_W(64), .CTRL_BUBBLE(BUB), .DATA_FLUSH_CLR(1'b1),
                           .SKID(1'b0), .CNT_W(16)) u_s0 (
    .i_PIPE_REG_clk(clk), .i_PIPE_REG_rst_n(rst_n), .i_PIPE_REG_flush(flush),
    .i_PIPE_REG_in_valid(in_valid), .o_PIPE_REG_in_ready(rdy0),
    .i_PIPE_REG_ctrl(ctrl), .i_PIPE_REG_data(data),
    .o_PIPE_REG_out_valid(vld0), .i_PIPE_REG_out_ready(out_ready),
    .o_PIPE_REG_ctrl(oc0), .o_PIPE_REG_data(od0), .o_PIPE_REG_bubble_cnt(cnt0));

  ysyx_22040386_pipe_reg #(.CTRL_W(16), .DATA_W(64), .CTRL_BUBBLE(BUB), .DATA_FLUSH_CLR(1'b1),
                           .SKID(1'b1), .CNT_W(16)) u_s1 (
    .i_PIPE_REG_clk(clk), .i_PIPE_REG_rst_n(rst_n), .i_PIPE_REG_flush(flush),
    .i_PIPE_REG_in_valid(in_valid), .o_PIPE_REG_in_ready(rdy1),
    .i_PIPE_REG_ctrl(ctrl), .i_PIPE_REG_data(data),
    .o_PIPE_REG_out_valid(vld1), .i_PIPE_REG_out_ready(out_ready),
    .o_PIPE_REG_ctrl(oc1), .o_PIPE_REG_data(od1), .o_PIPE_REG_bubble_cnt(cnt1));

  ysyx_22040386_pipe_reg #(.CTRL_W(16), .DATA_W(64), .CTRL_BUBBLE(BUB), .DATA_FLUSH_CLR(1'b1),
                           .SKID(1'b0), .CNT_W(4)) u_c4 (
    .i_PIPE_REG_clk(clk), .i_PIPE_REG_rst_n(rst_n), .i_PIPE_REG_flush(flush),
    .i_PIPE_REG_in_valid(in_valid), .o_PIPE_REG_in_ready(rdy4),
    .i_PIPE_REG_ctrl(ctrl), .i_PIPE_REG_data(data),
    .o_PIPE_REG_out_valid(vld4), .i_PIPE_REG_out_ready(out_ready),
    .o_PIPE_REG_ctrl(oc4), .o_PIPE_REG_data(od4), .o_PIPE_REG_bubble_cnt(cnt4));

  typedef struct {
    logic        rst_n, flush, in_valid;
    logic [15:0] ctrl;
    logic [63:0] data;
    logic        out_ready;
    logic        exp_valid;
    logic [15:0] exp_c0, exp_c1;
    logic        exp_rdy1;
    logic [15:0] exp_cnt;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[24];

  function automatic logic [63:0] dval(input logic [15:0] c);
    return {48'hD00D_0000_0000, c};
  endfunction

  function automatic vec_t mk(input logic r, f, iv, input logic [15:0] c, input logic ordy,
                              input logic ev, input logic [15:0] c0, c1, input logic r1,
                              input logic [15:0] cnt, input logic dz);
    vec_t v;
    v.rst_n = r; v.flush = f; v.in_valid = iv; v.ctrl = c; v.data = dval(c);
    v.out_ready = ordy; v.exp_valid = ev; v.exp_c0 = c0; v.exp_c1 = c1;
    v.exp_rdy1 = r1; v.exp_cnt = cnt; v.exp_dz = dz;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, f, iv, input logic [15:0] c, input logic [63:0] d,
                       input logic ordy);
    rst_n = r; flush = f; in_valid = iv; ctrl = c; data = d; out_ready = ordy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //             rst  fl   iv   ctrl      ordy  valid c0        c1        rdy1  cnt  dz
    vecs[0]  = mk(1'b0,1'b0,1'b1,16'hFFFF,1'b0, 1'b0,BUB,      BUB,      1'b1, 16'd0,1'b1);
    vecs[1]  = mk(1'b0,1'b0,1'b1,16'hFFFF,1'b0, 1'b0,BUB,      BUB,      1'b1, 16'd0,1'b1);
    vecs[2]  = mk(1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b0,BUB,      BUB,      1'b1, 16'd1,1'b0);
    vecs[3]  = mk(1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b0,BUB,      BUB,      1'b1, 16'd2,1'b0);
    vecs[4]  = mk(1'b1,1'b0,1'b1,16'h0001,1'b1, 1'b1,16'h0001,16'h0001,1'b1, 16'd3,1'b0);
    vecs[5]  = mk(1'b1,1'b0,1'b1,16'h0002,1'b1, 1'b1,16'h0002,16'h0002,1'b1, 16'd3,1'b0);
    vecs[6]  = mk(1'b1,1'b0,1'b1,16'h0003,1'b1, 1'b1,16'h0003,16'h0003,1'b1, 16'd3,1'b0);
    vecs[7]  = mk(1'b1,1'b0,1'b0,16'h0004,1'b1, 1'b0,BUB,      BUB,      1'b1, 16'd3,1'b0);
    vecs[8]  = mk(1'b1,1'b0,1'b1,16'h000A,1'b0, 1'b1,16'h000A,16'h000A,1'b1, 16'd4,1'b0);
    vecs[9]  = mk(1'b1,1'b0,1'b1,16'h000B,1'b0, 1'b1,16'h000A,16'h000A,1'b0, 16'd4,1'b0);
    vecs[10] = mk(1'b1,1'b0,1'b1,16'h000C,1'b0, 1'b1,16'h000A,16'h000A,1'b0, 16'd4,1'b0);
    vecs[11] = mk(1'b1,1'b0,1'b1,16'h000C,1'b1, 1'b1,16'h000C,16'h000B,1'b1, 16'd4,1'b0);
    vecs[12] = mk(1'b1,1'b0,1'b1,16'h000C,1'b1, 1'b1,16'h000C,16'h000C,1'b1, 16'd4,1'b0);
    vecs[13] = mk(1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b0,BUB,      BUB,      1'b1, 16'd4,1'b0);
    vecs[14] = mk(1'b1,1'b0,1'b1,16'h0011,1'b0, 1'b1,16'h0011,16'h0011,1'b1, 16'd5,1'b0);
    vecs[15] = mk(1'b1,1'b0,1'b1,16'h0012,1'b0, 1'b1,16'h0011,16'h0011,1'b0, 16'd5,1'b0);
    vecs[16] = mk(1'b1,1'b1,1'b1,16'h0013,1'b0, 1'b0,BUB,      BUB,      1'b1, 16'd5,1'b1);
    vecs[17] = mk(1'b1,1'b0,1'b0,16'h0000,1'b0, 1'b0,BUB,      BUB,      1'b1, 16'd6,1'b0);
    vecs[18] = mk(1'b1,1'b0,1'b1,16'h0021,1'b1, 1'b1,16'h0021,16'h0021,1'b1, 16'd7,1'b0);
    vecs[19] = mk(1'b1,1'b1,1'b1,16'h0022,1'b1, 1'b0,BUB,      BUB,      1'b1, 16'd7,1'b1);
    vecs[20] = mk(1'b1,1'b0,1'b1,16'h0031,1'b0, 1'b1,16'h0031,16'h0031,1'b1, 16'd8,1'b0);
    vecs[21] = mk(1'b1,1'b0,1'b1,16'h0032,1'b0, 1'b1,16'h0031,16'h0031,1'b0, 16'd8,1'b0);
    vecs[22] = mk(1'b0,1'b1,1'b1,16'h0033,1'b0, 1'b0,BUB,      BUB,      1'b1, 16'd0,1'b1);
    vecs[23] = mk(1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b0,BUB,      BUB,      1'b1, 16'd1,1'b0);
    vecs[16].data = 64'h8000_0004;

    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].rst_n, vecs[i].flush, vecs[i].in_valid, vecs[i].ctrl, vecs[i].data,
            vecs[i].out_ready);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d s0 valid", i), 64'(vld0), 64'(vecs[i].exp_valid));
      check($sformatf("v%0d s0 ctrl", i), 64'(oc0), 64'(vecs[i].exp_c0));
      check($sformatf("v%0d s1 valid", i), 64'(vld1), 64'(vecs[i].exp_valid));
      check($sformatf("v%0d s1 ctrl", i), 64'(oc1), 64'(vecs[i].exp_c1));
      check($sformatf("v%0d s1 in_ready", i), 64'(rdy1), 64'(vecs[i].exp_rdy1));
      check($sformatf("v%0d s0 bubble_cnt", i), 64'(cnt0), 64'(vecs[i].exp_cnt));
      check($sformatf("v%0d s1 bubble_cnt", i), 64'(cnt1), 64'(vecs[i].exp_cnt));
      check($sformatf("v%0d c4 bubble_cnt", i), 64'(cnt4), 64'(vecs[i].exp_cnt[3:0]));
      if (vecs[i].exp_dz) begin
        check($sformatf("v%0d s0 data zero", i), od0, 64'd0);
        check($sformatf("v%0d s1 data zero", i), od1, 64'd0);
      end else if (vecs[i].exp_valid) begin
        check($sformatf("v%0d s0 data", i), od0, dval(vecs[i].exp_c0));
        check($sformatf("v%0d s1 data", i), od1, dval(vecs[i].exp_c1));
      end
    end

    // SKID=0 ready follows out_ready within the cycle; SKID=1 ready does not.
    drive(1'b1, 1'b0, 1'b1, 16'h0041, dval(16'h0041), 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1 check("s0 in_ready stalled", 64'(rdy0), 64'd0);
    out_ready = 1'b1;
    #1 check("s0 in_ready comb", 64'(rdy0), 64'd1);
    drive(1'b1, 1'b0, 1'b1, 16'h0042, dval(16'h0042), 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("s1 full in_ready", 64'(rdy1), 64'd0);
    out_ready = 1'b1;
    #1 check("s1 in_ready registered", 64'(rdy1), 64'd0);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("s1 skid->main valid", 64'(vld1), 64'd1);
    check("s1 skid->main ctrl", 64'(oc1), 64'(16'h0042));
    check("s1 skid->main data", od1, dval(16'h0042));
    check("s1 skid->main in_ready", 64'(rdy1), 64'd1);
    check("s0 drained ctrl", 64'(oc0), 64'(BUB));
    @(posedge clk);
    @(negedge clk);
    check("s1 drained valid", 64'(vld1), 64'd0);
    check("s1 drained ctrl", 64'(oc1), 64'(BUB));

    // Counter wrap: 17 empty cycles after reset.
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 64'd0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (17) @(posedge clk);
    @(negedge clk);
    check("c4 bubble_cnt wrap", 64'(cnt4), 64'd1);
    check("s0 bubble_cnt 17", 64'(cnt0), 64'd17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
